// File: rtl/stage_seq_ctrl.sv
// stage_seq_ctrl
// Per-stage sequencer for a ping-pong SRAM pair. Each stage streams read
// addresses 0..len-1 out of the current source SRAM (select_sram) into the
// compute pipe. The matching write-back addresses come out PIPE_LAT cycles
// later, aimed at the opposite SRAM. When the pipe has drained, the block
// pulses new_stage_trigger with status=1. The downstream toggle register
// then swaps source and destination, and its select output comes back in on
// select_sram for the next stage. An abort ends the run with a status=0
// trigger and no swap.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, abort        one-cycle control pulses
//   cfg_num_stages      stages per run (latched at start)
//   cfg_stage_len       words per stage, 0..2^ADDR_W (latched at start)
//   select_sram         current source SRAM from the toggle register
//   proc_ready          compute pipe can accept a read this cycle
//   rd_en/rd_addr/rd_sram_sel   read side toward the source SRAM
//   wr_en/wr_addr/wr_sram_sel   write side toward the destination SRAM
//   new_stage_trigger/status    stage-boundary pulse and its qualifier
//   stage_idx, busy, done       run progress
//
// Handshake: a read is issued only in a cycle where rd_en=1. rd_en is never
// high while proc_ready=0. There is no back-pressure on the write side:
// wr_en is rd_en delayed exactly PIPE_LAT cycles.
module stage_seq_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int STAGE_W  = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [STAGE_W-1:0] cfg_num_stages,
  input  logic [ADDR_W:0]   cfg_stage_len,
  input  logic              select_sram,
  input  logic              proc_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_sram_sel,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_sram_sel,
  output logic              new_stage_trigger,
  output logic              status,
  output logic [STAGE_W-1:0] stage_idx,
  output logic              busy,
  output logic              done
);

  // S_ABRT issues the status=0 trigger. S_ADRN waits for in-flight writes
  // to leave the pipe before the block returns to idle.
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_SWAP, S_SYNC, S_FIN, S_ABRT, S_ADRN
  } state_t;

  localparam logic [ADDR_W:0]    CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [STAGE_W-1:0] STG_ONE = {{(STAGE_W-1){1'b0}}, 1'b1};

  state_t              state, state_nxt;
  logic [STAGE_W-1:0]  num_stages_q;
  logic [ADDR_W:0]     stage_len_q;
  logic [ADDR_W:0]     rd_cnt;      // one bit wider so len=2^ADDR_W fits
  logic [PIPE_LAT-1:0] pipe_v;
  logic [ADDR_W-1:0]   pipe_a [PIPE_LAT];
  logic                pipe_empty;
  logic                last_rd;
  logic                abort_act;
  logic                last_stage;

  assign pipe_empty = (pipe_v == '0);
  assign last_rd    = ((rd_cnt + CNT_ONE) == stage_len_q);
  assign last_stage = ((stage_idx + STG_ONE) == num_stages_q);
  assign abort_act  = abort && (state == S_ISSUE || state == S_DRAIN ||
                                state == S_SWAP  || state == S_SYNC);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (cfg_num_stages == '0) ? S_FIN : S_ISSUE;
      S_ISSUE: begin
        if (abort_act)                state_nxt = S_ABRT;
        else if (stage_len_q == '0)   state_nxt = S_DRAIN;
        else if (rd_en && last_rd)    state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort_act)       state_nxt = S_ABRT;
        else if (pipe_empty) state_nxt = S_SWAP;
      end
      S_SWAP:  state_nxt = abort_act ? S_ABRT : S_SYNC;
      S_SYNC: begin
        if (abort_act)       state_nxt = S_ABRT;
        else if (last_stage) state_nxt = S_FIN;
        else                 state_nxt = S_ISSUE;
      end
      S_FIN:   state_nxt = S_IDLE;
      S_ABRT:  state_nxt = pipe_empty ? S_IDLE : S_ADRN;
      S_ADRN:  if (pipe_empty) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic. rd_en is gated by abort in the same cycle, so no read
  // leaves the block from the abort cycle onward.
  always_comb begin
    rd_en             = (state == S_ISSUE) && proc_ready && !abort &&
                        (stage_len_q != '0);
    rd_addr           = rd_cnt[ADDR_W-1:0];
    rd_sram_sel       = select_sram;
    wr_en             = pipe_v[PIPE_LAT-1];
    wr_addr           = pipe_a[PIPE_LAT-1];
    wr_sram_sel       = ~select_sram;
    new_stage_trigger = (state == S_SWAP) || (state == S_ABRT);
    status            = (state == S_SWAP);
    busy              = (state != S_IDLE);
    done              = (state == S_FIN);
  end

  // Configuration, stage index and read counter
  always_ff @(posedge clk) begin
    if (rst) begin
      num_stages_q <= '0;
      stage_len_q  <= '0;
      stage_idx    <= '0;
      rd_cnt       <= '0;
    end else if (state == S_IDLE && start) begin
      num_stages_q <= cfg_num_stages;
      stage_len_q  <= cfg_stage_len;
      stage_idx    <= '0;
      rd_cnt       <= '0;
    end else if (rd_en) begin
      rd_cnt <= rd_cnt + CNT_ONE;
    end else if (state == S_SYNC && state_nxt == S_ISSUE) begin
      stage_idx <= stage_idx + STG_ONE;
      rd_cnt    <= '0;
    end
  end

  // Write-address delay line. The valid bit of each entry marks a real
  // write-back. The address travels with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < PIPE_LAT; i++) pipe_a[i] <= '0;
    end else begin
      pipe_v[0] <= rd_en;
      pipe_a[0] <= rd_cnt[ADDR_W-1:0];
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
    end
  end

endmodule

// File: tb/tb_stage_seq_ctrl.sv
// Bench for stage_seq_ctrl. A model of the downstream toggle register closes
// the select loop. A scoreboard keeps each issued read (due cycle,
// destination SRAM, address) and matches it against the write-back. Run-level
// totals are computed from the configuration.
module tb_stage_seq_ctrl;
  localparam int ADDR_W   = 8;
  localparam int STAGE_W  = 4;
  localparam int PIPE_LAT = 3;
  localparam int QW       = 32 + 1 + ADDR_W;

  logic clk, rst, start, abort, select_sram, proc_ready;
  logic [STAGE_W-1:0] cfg_num_stages;
  logic [ADDR_W:0]    cfg_stage_len;
  logic rd_en, rd_sram_sel, wr_en, wr_sram_sel, new_stage_trigger, status, busy, done;
  logic [ADDR_W-1:0]  rd_addr, wr_addr;
  logic [STAGE_W-1:0] stage_idx;

  stage_seq_ctrl #(.ADDR_W(ADDR_W), .STAGE_W(STAGE_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_num_stages(cfg_num_stages), .cfg_stage_len(cfg_stage_len),
    .select_sram(select_sram), .proc_ready(proc_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_sram_sel(rd_sram_sel),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_sram_sel(wr_sram_sel),
    .new_stage_trigger(new_stage_trigger), .status(status),
    .stage_idx(stage_idx), .busy(busy), .done(done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Toggle register: swaps on a status=1 trigger.
  always @(posedge clk) begin
    if (rst) select_sram <= 1'b0;
    else if (new_stage_trigger && status) select_sram <= ~select_sram;
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_addr = 0;
  int cur_len  = 0;
  int n_rd, n_wr, n_ok, n_ab, n_done, max_rd;
  logic prev_trig, prev_status;
  logic [QW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_stats();
    n_rd = 0; n_wr = 0; n_ok = 0; n_ab = 0; n_done = 0; max_rd = 0;
  endtask

  // Monitor: samples on the falling edge.
  always @(negedge clk) begin
    logic [QW-1:0] e;
    logic [31:0]   due;
    cyc++;
    if (rst) begin
      exp_q.delete();
      prev_trig   = 1'b0;
      prev_status = 1'b0;
    end else begin
      if (rd_en) begin
        chk("rd_gate", proc_ready, 1);
        chk("rd_addr", rd_addr, exp_addr);
        chk("rd_sel", rd_sram_sel, select_sram);
        due = cyc + PIPE_LAT;
        exp_q.push_back({due, ~select_sram, rd_addr});
        if (int'(rd_addr) > max_rd) max_rd = int'(rd_addr);
        exp_addr++;
        n_rd++;
      end
      if (wr_en) begin
        if (exp_q.size() == 0) chk("wr_spurious", wr_en, 0);
        else begin
          e = exp_q.pop_front();
          chk("wr_time", cyc, e[QW-1 -: 32]);
          chk("wr_sel", wr_sram_sel, e[ADDR_W]);
          chk("wr_addr", wr_addr, e[ADDR_W-1:0]);
        end
        n_wr++;
      end
      if (new_stage_trigger) begin
        if (prev_trig) chk("trig_pair", {prev_status, status}, 2'b10);
        if (status) begin
          n_ok++;
          chk("swap_reads", exp_addr, cur_len);
          chk("swap_drained", exp_q.size(), 0);
          exp_addr = 0;
        end else n_ab++;
      end
      prev_trig   = new_stage_trigger;
      prev_status = status;
      if (done) n_done++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_ready(input int mode);
    if (mode == 0)      proc_ready = 1'b1;
    else if (mode == 1) proc_ready = ~proc_ready;
    else                proc_ready = 1'($urandom_range(0, 1));
  endtask

  // mode: 0 always ready, 1 toggling, 2 random. abort_at>=1 aborts once that
  // many reads have been issued in stage 0 (must be below len).
  task automatic run(input int ns, input int len, input int mode,
                     input int abort_at, input bit start_abort);
    logic sel0;
    bit   aborted;
    clear_stats();
    sel0     = select_sram;
    cur_len  = len;
    exp_addr = 0;
    aborted  = 0;
    @(posedge clk); #1;
    cfg_num_stages = STAGE_W'(ns);
    cfg_stage_len  = (ADDR_W+1)'(len);
    start = 1'b1;
    abort = start_abort;
    proc_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    drive_ready(mode);
    @(negedge clk);
    chk("busy_rise", busy, 1);
    if (ns == 0) chk("done_zero_cfg", done, 1);
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
      abort = 1'b0;
      if (abort_at >= 1 && !aborted && n_rd == abort_at) begin
        abort   = 1'b1;
        aborted = 1;
      end
      drive_ready(mode);
      @(negedge clk);
    end
    chk("run_end_busy", busy, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("wr_count", n_wr, n_rd);
    chk("queue_empty", exp_q.size(), 0);
    if (abort_at >= 1) begin
      chk("abort_reads", n_rd, abort_at);
      chk("abort_trig", n_ab, 1);
      chk("abort_no_swap", n_ok, 0);
      chk("abort_no_done", n_done, 0);
      chk("abort_sel", select_sram, sel0);
    end else begin
      chk("reads_total", n_rd, ns * len);
      chk("swap_count", n_ok, ns);
      chk("no_abort_trig", n_ab, 0);
      chk("done_count", n_done, 1);
      chk("sel_final", select_sram, sel0 ^ 1'(ns));
      chk("stage_idx_hold", stage_idx, (ns == 0) ? 0 : ns - 1);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_trig"}, new_stage_trigger, 0);
    chk({tag, "_status"}, status, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_stage_idx"}, stage_idx, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ns, len, ab;
    rst = 1'b1; start = 1'b0; abort = 1'b0; proc_ready = 1'b0;
    cfg_num_stages = '0; cfg_stage_len = '0;
    clear_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run(2, 4, 0, -1, 0);     // basic
    run(1, 5, 1, -1, 0);     // backpressure
    run(0, 7, 0, -1, 0);     // zero stages
    run(1, 0, 0, -1, 0);     // zero length
    run(2, 6, 0, 2, 0);      // abort mid-ISSUE after 2 reads
    run(1, 3, 0, -1, 1);     // start and abort together in IDLE

    // Reset mid-DRAIN
    clear_stats();
    cur_len = 4; exp_addr = 0;
    @(posedge clk); #1;
    cfg_num_stages = 4'd1; cfg_stage_len = 9'd4; start = 1'b1; proc_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50 && n_rd < 4; i++) @(negedge clk);
    chk("rst_pre_reads", n_rd, 4);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    repeat (6) @(negedge clk);
    chk("midrst_no_trig", n_ok + n_ab, 0);
    run(1, 3, 0, -1, 0);

    // Full length
    run(1, 256, 2, -1, 0);
    chk("full_last_addr", max_rd, 255);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      ns  = $urandom_range(1, 3);
      len = $urandom_range(0, 12);
      ab  = -1;
      if (len >= 2 && $urandom_range(0, 2) == 0) ab = $urandom_range(1, len - 1);
      run(ns, len, 2, ab, 0);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
